// File: rtl/digit_bank_arbiter.sv
// Two-requester arbiter that services increment/decrement-mod-10 operations on a shared BCD digit memory.
// Define DIGIT_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise requester 0 wins ties.
module digit_bank_arbiter #(
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  op0,
  input  logic                  op1,
  input  logic [3:0]            addr0,
  input  logic [3:0]            addr1,
  input  logic [4*DIGITS-1:0]   mem,
  output logic                  we,
  output logic [4*DIGITS-1:0]   mem_in,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic                  err,
  output logic                  busy,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [4:0] DIGITS_W = 5'(DIGITS);

  state_t     state_q, state_d;
  logic       win_q, win_d;
  logic       op_q, op_d;
  logic [3:0] addr_q, addr_d;
  logic       pick;
  logic       addr_ok;

`ifdef DIGIT_ARB_ROUND_ROBIN_EN
  // prio_q names the requester that wins the next tie; it flips away from each winner.
  logic prio_q, prio_d;
  always_comb pick = (req0 & req1) ? prio_q : req1;
`else
  always_comb pick = ~req0;
`endif

  assign addr_ok = ({1'b0, addr_q} < DIGITS_W);

  function automatic logic [3:0] next_digit(input logic [3:0] d, input logic dec);
    logic [3:0] r;
    if (!dec) begin
      r = (d >= 4'd9) ? 4'd0 : d + 4'd1;
    end else begin
      // Codes 10..15 behave as 10, so they decrement to 9 just like 0 wraps to 9.
      r = (d == 4'd0 || d >= 4'd10) ? 4'd9 : d - 4'd1;
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    op_d    = op_q;
    addr_d  = addr_q;
`ifdef DIGIT_ARB_ROUND_ROBIN_EN
    prio_d  = prio_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          win_d   = pick;
          op_d    = pick ? op1 : op0;
          addr_d  = pick ? addr1 : addr0;
          state_d = S_WRITE;
`ifdef DIGIT_ARB_ROUND_ROBIN_EN
          prio_d  = ~pick;
`endif
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      win_q   <= 1'b0;
      op_q    <= 1'b0;
      addr_q  <= 4'd0;
`ifdef DIGIT_ARB_ROUND_ROBIN_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
`ifdef DIGIT_ARB_ROUND_ROBIN_EN
      prio_q  <= prio_d;
`endif
    end
  end

  always_comb begin
    mem_in = mem;
    if (state_q == S_WRITE && addr_ok) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (addr_q == 4'(k)) mem_in[4*k +: 4] = next_digit(mem[4*k +: 4], op_q);
      end
    end
  end

  assign we        = (state_q == S_WRITE) & addr_ok;
  assign gnt0      = (state_q == S_WRITE) & ~win_q;
  assign gnt1      = (state_q == S_WRITE) &  win_q;
  assign done0     = (state_q == S_DONE)  & ~win_q;
  assign done1     = (state_q == S_DONE)  &  win_q;
  assign err       = (state_q == S_DONE)  & ~addr_ok;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_digit_bank_arbiter.sv
// Directed bench for digit_bank_arbiter (DIGITS=10); expected values are hand-computed constants.
module tb_digit_bank_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic [3:0]  addr0 = 4'd0, addr1 = 4'd0;
  logic [39:0] mem = 40'h0;
  logic        we, gnt0, gnt1, done0, done1, err, busy;
  logic [39:0] mem_in;
  logic [1:0]  state_dbg;

  int vectors = 0;
  int miscompares = 0;

  digit_bank_arbiter #(.DIGITS(10)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .addr0(addr0), .addr1(addr1), .mem(mem),
    .we(we), .mem_in(mem_in), .gnt0(gnt0), .gnt1(gnt1),
    .done0(done0), .done1(done1), .err(err), .busy(busy),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request, drops it in WRITE, and checks the WRITE and DONE cycles.
  task automatic service(input string tag, input logic who, input logic op, input logic [3:0] addr,
                         input logic [39:0] m, input logic [39:0] exp_mem_in,
                         input logic exp_we, input logic exp_err);
    mem = m;
    if (!who) begin req0 = 1'b1; op0 = op; addr0 = addr; end
    else      begin req1 = 1'b1; op1 = op; addr1 = addr; end
    step();
    req0 = 1'b0; req1 = 1'b0;
    chk1({tag, "_gnt0"}, gnt0, ~who);
    chk1({tag, "_gnt1"}, gnt1, who);
    chk1({tag, "_we"}, we, exp_we);
    chkw({tag, "_mem_in"}, mem_in, exp_mem_in);
    chk1({tag, "_busy_w"}, busy, 1'b1);
    step();
    chk1({tag, "_done0"}, done0, ~who);
    chk1({tag, "_done1"}, done1, who);
    chk1({tag, "_err"}, err, exp_err);
    chk1({tag, "_we_d"}, we, 1'b0);
    chkw({tag, "_mem_in_d"}, mem_in, m);
    chk1({tag, "_busy_d"}, busy, 1'b1);
    step();
    chk1({tag, "_busy_i"}, busy, 1'b0);
    chk1({tag, "_done_i"}, done0 | done1, 1'b0);
  endtask

  logic exp_g0, exp_g1;

  initial begin
    // Reset state while reset is held
    mem = 40'h9999999999;
    #12;
    chk1("rst_we", we, 1'b0);
    chk1("rst_gnt", gnt0 | gnt1, 1'b0);
    chk1("rst_done", done0 | done1, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chkw("rst_mem_in", mem_in, 40'h9999999999);
    step();
    reset = 1'b0;
    step();
    chk1("idle_busy", busy, 1'b0);

    service("inc9_a3",   1'b0, 1'b0, 4'd3,  40'h9999999999, 40'h9999990999, 1'b1, 1'b0);
    service("dec0_a0",   1'b1, 1'b1, 4'd0,  40'h9999999990, 40'h9999999999, 1'b1, 1'b0);
    service("incC_a5",   1'b0, 1'b0, 4'd5,  40'h0000C00000, 40'h0000000000, 1'b1, 1'b0);
    service("decC_a5",   1'b1, 1'b1, 4'd5,  40'h0000C00000, 40'h0000900000, 1'b1, 1'b0);
    service("dec1_a9",   1'b0, 1'b1, 4'd9,  40'h1234567890, 40'h0234567890, 1'b1, 1'b0);
    service("inc9_a1",   1'b1, 1'b0, 4'd1,  40'h1234567890, 40'h1234567800, 1'b1, 1'b0);
    service("inc4_a6",   1'b0, 1'b0, 4'd6,  40'h1234567890, 40'h1235567890, 1'b1, 1'b0);
    service("oob_a12",   1'b0, 1'b0, 4'd12, 40'h1234567890, 40'h1234567890, 1'b0, 1'b1);
    service("oob_a10",   1'b1, 1'b1, 4'd10, 40'h1234567890, 40'h1234567890, 1'b0, 1'b1);

    // Reset asserted in the middle of a WRITE cycle
    mem = 40'h9999999999;
    req0 = 1'b1; op0 = 1'b0; addr0 = 4'd3;
    step();
    chk1("midrst_gnt0_pre", gnt0, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("midrst_we", we, 1'b0);
    chk1("midrst_gnt0", gnt0, 1'b0);
    chk1("midrst_busy", busy, 1'b0);
    chkw("midrst_mem_in", mem_in, 40'h9999999999);
    req0 = 1'b0;
    step();
    chk1("midrst_nodone_a", done0, 1'b0);
    step();
    chk1("midrst_nodone_b", done0, 1'b0);
    reset = 1'b0;
    step();
    chk1("midrst_nodone_c", done0, 1'b0);
    service("post_rst", 1'b0, 1'b0, 4'd3, 40'h9999999999, 40'h9999990999, 1'b1, 1'b0);

    // Fresh reset so the tie-break pointer starts at requester 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    mem = 40'h9999999999;
    req0 = 1'b1; op0 = 1'b0; addr0 = 4'd1;
    req1 = 1'b1; op1 = 1'b0; addr1 = 4'd2;
    for (int s = 0; s < 12; s++) begin
      step();
      exp_g0 = 1'b0;
      exp_g1 = 1'b0;
      if (s % 3 == 0) begin
`ifdef DIGIT_ARB_ROUND_ROBIN_EN
        exp_g0 = ((s / 3) % 2 == 0);
        exp_g1 = ((s / 3) % 2 == 1);
`else
        exp_g0 = 1'b1;
`endif
      end
      chk1($sformatf("tie_gnt0_s%0d", s), gnt0, exp_g0);
      chk1($sformatf("tie_gnt1_s%0d", s), gnt1, exp_g1);
      if (exp_g0) chkw($sformatf("tie_mem_in_s%0d", s), mem_in, 40'h9999999909);
      if (exp_g1) chkw($sformatf("tie_mem_in_s%0d", s), mem_in, 40'h9999999099);
      chk1($sformatf("tie_busy_s%0d", s), busy, (s % 3) != 2);
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
